// File: rtl/jk_seq_pkg.sv
// Shared types for the JK bank sequencer: op encoding, FSM states, command record
// and the expected-readback rule.
package jk_seq_pkg;

    // Command fields are stored at these widths; narrower ports are zero-extended.
    localparam int unsigned CmdIdxW = 8;
    localparam int unsigned CmdCntW = 8;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TOG  = 2'b11
    } jk_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrive,
        StCheck
    } seq_state_t;

    typedef struct packed {
        logic [CmdIdxW-1:0] idx;
        jk_op_t             op;
        logic [CmdCntW-1:0] cnt;
    } jk_cmd_t;

    function automatic logic jk_expected(input jk_op_t op, input logic q0, input logic n_lsb);
        logic res;
        res = q0;
        case (op)
            OP_HOLD: res = q0;
            OP_RST:  res = 1'b0;
            OP_SET:  res = 1'b1;
            OP_TOG:  res = q0 ^ n_lsb;
            default: res = q0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; flags come from a registered occupancy count, so a pop
// on a full FIFO frees space only from the following cycle.
module jk_cmd_fifo
    import jk_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  jk_cmd_t wdata_i,
    input  logic    pop_i,
    output jk_cmd_t rdata_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    jk_cmd_t         mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven J/K pin sequencer: pops queued {idx, op, cnt} commands, drives one
// flop for max(cnt,1) cycles, then checks its readback against the predicted value.
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [$clog2(WIDTH)-1:0] cmd_idx_i,
    input  logic [1:0]               cmd_op_i,
    input  logic [CNT_W-1:0]         cmd_cnt_i,
    output logic [WIDTH-1:0]         j_o,
    output logic [WIDTH-1:0]         k_o,
    input  logic [WIDTH-1:0]         q_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    seq_state_t       state_q;
    jk_cmd_t          cmd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q0_q;
    logic [WIDTH-1:0] j_q, k_q;
    logic             done_q, err_q;

    jk_cmd_t          fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [WIDTH-1:0] sel;
    logic [1:0]       op_bits;
    logic [CNT_W-1:0] n_load;
    logic             q_bit, idx_ok, exp_bit;
    logic             unused_cnt;

    assign fifo_wdata.idx = CmdIdxW'(cmd_idx_i);
    assign fifo_wdata.op  = jk_op_t'(cmd_op_i);
    assign fifo_wdata.cnt = CmdCntW'(cmd_cnt_i);
    assign fifo_pop       = (state_q == StIdle) && !fifo_empty;

    jk_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // One-hot select is all-zero for an out-of-range index, so no pin is driven.
    assign sel        = WIDTH'(1) << cmd_q.idx;
    assign idx_ok     = |sel;
    assign q_bit      = |(q_i & sel);
    assign op_bits    = cmd_q.op;
    assign n_load     = (cmd_q.cnt[CNT_W-1:0] == '0) ? CNT_W'(1) : cmd_q.cnt[CNT_W-1:0];
    assign exp_bit    = jk_expected(cmd_q.op, q0_q, n_load[0]);
    assign unused_cnt = ^cmd_q.cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            cnt_q   <= '0;
            q0_q    <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // The FIFO head is gone after the pop, so capture it here.
                    if (!fifo_empty) begin
                        cmd_q   <= fifo_rdata;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    q0_q    <= q_bit;
                    cnt_q   <= n_load;
                    j_q     <= op_bits[1] ? sel : '0;
                    k_q     <= op_bits[0] ? sel : '0;
                    state_q <= StDrive;
                end
                StDrive: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        j_q     <= '0;
                        k_q     <= '0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (!idx_ok || (q_bit != exp_bit)) err_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign j_o         = j_q;
    assign k_o         = k_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != StIdle) || !fifo_empty;
    assign cmd_ready_o = !fifo_full;

endmodule
